// File: rtl/hwag_sync_pkg.sv
// Shared types and helpers for the crank tooth synchroniser.
// Holds the sync state encoding, default wheel geometry and the gap compare.
package hwag_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        SYNC   = 2'd3
    } sync_state_t;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_TW        = 6;
    localparam int DEF_TEETH     = 58;
    localparam int DEF_GAP_SHIFT = 1;

    // Operands arrive zero-extended to 64 bits so the shifted prev never wraps.
    function automatic logic gap_check(input logic [63:0] cur,
                                       input logic [63:0] prev,
                                       input int          shift);
        return (cur > (prev << shift));
    endfunction

endpackage

// File: rtl/hwag_period_meter.sv
// Tooth period meter: saturating tick counter, edge capture, two-deep
// period history with a valid-depth count, and a stopped-wheel flag.
module hwag_period_meter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic             i_edge,
    input  logic             i_count_en,
    input  logic             i_hist_clr,
    output logic [WIDTH-1:0] o_capture,
    output logic [WIDTH-1:0] o_period_cur,
    output logic [WIDTH-1:0] o_period_prev,
    output logic [1:0]       o_hv,
    output logic             o_stall,
    output logic             o_stall_rise
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic             r_stall;
    logic             w_stall_next;
    logic [WIDTH-1:0] r_period_cur;
    logic [WIDTH-1:0] r_period_prev;
    logic [1:0]       r_hv;

    // Next counter value: an edge reloads (counting this cycle's tick), otherwise saturate-increment.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_edge) begin
            w_cnt_next = i_ena ? CNT_ONE : {WIDTH{1'b0}};
        end else if (i_ena && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    assign w_stall_next = (w_cnt_next == CNT_MAX);
    assign o_stall_rise = w_stall_next && !r_stall;

    // Counter and stall flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= {WIDTH{1'b0}};
            r_stall <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_stall <= w_stall_next;
        end
    end

    // Period history; hv only counts edges that close a real period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cur  <= {WIDTH{1'b0}};
            r_period_prev <= {WIDTH{1'b0}};
            r_hv          <= 2'd0;
        end else begin
            if (i_edge) begin
                r_period_prev <= r_period_cur;
                r_period_cur  <= r_cnt;
            end
            if (i_hist_clr) begin
                r_hv <= 2'd0;
            end else if (i_edge && i_count_en && (r_hv != 2'd2)) begin
                r_hv <= r_hv + 2'd1;
            end
        end
    end

    assign o_capture     = r_cnt;
    assign o_period_cur  = r_period_cur;
    assign o_period_prev = r_period_prev;
    assign o_hv          = r_hv;
    assign o_stall       = r_stall;

endmodule

// File: rtl/hwag_tooth_sync.sv
// Missing-tooth synchroniser: finds the gap, verifies one full revolution,
// then tracks the tooth index and flags loss of sync or a stopped wheel.
module hwag_tooth_sync
    import hwag_sync_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TW        = DEF_TW,
    parameter int TEETH     = DEF_TEETH,
    parameter int GAP_SHIFT = DEF_GAP_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             edge_in,
    output logic             sync,
    output logic [TW-1:0]    tooth_num,
    output logic             gap_pulse,
    output logic             sync_err,
    output logic             stall,
    output logic [WIDTH-1:0] period_cur,
    output logic [WIDTH-1:0] period_prev
);

    localparam logic [TW-1:0] LAST_TOOTH = TW'(TEETH - 1);
    localparam logic [TW-1:0] TW_ONE     = {{(TW-1){1'b0}}, 1'b1};

    sync_state_t      r_state;
    sync_state_t      w_state_next;
    logic [TW-1:0]    r_tooth;
    logic [TW-1:0]    w_tooth_next;
    logic [TW-1:0]    r_vcnt;
    logic [TW-1:0]    w_vcnt_next;
    logic             r_sync;
    logic             r_gap_pulse;
    logic             w_gap_pulse_next;
    logic             r_sync_err;
    logic             w_sync_err_next;
    logic             w_hist_clr;
    logic             w_count_en;
    logic             w_gap;
    logic             w_stall_rise;
    logic [WIDTH-1:0] w_capture;
    logic [1:0]       w_hv;

    assign w_count_en = (r_state != IDLE);

    hwag_period_meter #(
        .WIDTH (WIDTH)
    ) u_meter (
        .clk           (clk),
        .rst           (rst),
        .i_ena         (ena),
        .i_edge        (edge_in),
        .i_count_en    (w_count_en),
        .i_hist_clr    (w_hist_clr),
        .o_capture     (w_capture),
        .o_period_cur  (period_cur),
        .o_period_prev (period_prev),
        .o_hv          (w_hv),
        .o_stall       (stall),
        .o_stall_rise  (w_stall_rise)
    );

    assign w_gap = (w_hv != 2'd0) &&
                   gap_check(64'(w_capture), 64'(period_cur), GAP_SHIFT);

    // Sync state machine: stall takes priority, then tooth edges drive transitions.
    always_comb begin
        w_state_next     = r_state;
        w_tooth_next     = r_tooth;
        w_vcnt_next      = r_vcnt;
        w_gap_pulse_next = 1'b0;
        w_sync_err_next  = 1'b0;
        w_hist_clr       = 1'b0;
        if (w_stall_rise && (r_state != IDLE)) begin
            w_state_next    = IDLE;
            w_tooth_next    = {TW{1'b0}};
            w_hist_clr      = 1'b1;
            w_sync_err_next = (r_state == SYNC);
        end else if (edge_in) begin
            case (r_state)
                IDLE: begin
                    w_state_next = SEARCH;
                end
                SEARCH: begin
                    if (w_gap) begin
                        w_state_next = VERIFY;
                        w_vcnt_next  = {TW{1'b0}};
                    end else begin
                        w_state_next = SEARCH;
                    end
                end
                VERIFY: begin
                    if (w_gap) begin
                        if (r_vcnt == LAST_TOOTH) begin
                            w_state_next     = SYNC;
                            w_tooth_next     = {TW{1'b0}};
                            w_gap_pulse_next = 1'b1;
                        end else begin
                            w_state_next = SEARCH;
                        end
                    end else if (r_vcnt == LAST_TOOTH) begin
                        w_state_next = SEARCH;
                    end else begin
                        w_vcnt_next = r_vcnt + TW_ONE;
                    end
                end
                SYNC: begin
                    if (r_tooth == LAST_TOOTH) begin
                        w_tooth_next = {TW{1'b0}};
                        if (w_gap) begin
                            w_gap_pulse_next = 1'b1;
                        end else begin
                            w_sync_err_next = 1'b1;
                            w_state_next    = SEARCH;
                        end
                    end else if (w_gap) begin
                        // An early gap may be the true one, so re-verify from it.
                        w_sync_err_next = 1'b1;
                        w_state_next    = VERIFY;
                        w_vcnt_next     = {TW{1'b0}};
                        w_tooth_next    = {TW{1'b0}};
                    end else begin
                        w_tooth_next = r_tooth + TW_ONE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_tooth_next = {TW{1'b0}};
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tooth     <= {TW{1'b0}};
            r_vcnt      <= {TW{1'b0}};
            r_sync      <= 1'b0;
            r_gap_pulse <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tooth     <= w_tooth_next;
            r_vcnt      <= w_vcnt_next;
            r_sync      <= (w_state_next == SYNC);
            r_gap_pulse <= w_gap_pulse_next;
            r_sync_err  <= w_sync_err_next;
        end
    end

    assign sync      = r_sync;
    assign tooth_num = r_tooth;
    assign gap_pulse = r_gap_pulse;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Directed bench for hwag_tooth_sync: a table of tooth edges with expected
// outputs, plus hand sequences for mid-revolution reset and wheel stall.
module tb_hwag_tooth_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        edge_m;
    logic        edge_s;

    logic        m_sync, m_gp, m_err, m_stall;
    logic [5:0]  m_tn;
    logic [23:0] m_pc, m_pp;
    logic        s_sync, s_gp, s_err, s_stall;
    logic [5:0]  s_tn;
    logic [7:0]  s_pc, s_pp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hwag_tooth_sync dut (
        .clk (clk), .rst (rst), .ena (ena), .edge_in (edge_m),
        .sync (m_sync), .tooth_num (m_tn), .gap_pulse (m_gp), .sync_err (m_err),
        .stall (m_stall), .period_cur (m_pc), .period_prev (m_pp)
    );

    hwag_tooth_sync #(.WIDTH(8)) dut_s (
        .clk (clk), .rst (rst), .ena (ena), .edge_in (edge_s),
        .sync (s_sync), .tooth_num (s_tn), .gap_pulse (s_gp), .sync_err (s_err),
        .stall (s_stall), .period_cur (s_pc), .period_prev (s_pp)
    );

    typedef struct {
        bit tgt;
        int per;
        bit sync;
        int tn;
        bit gp;
        bit err;
        int pc;
        int pp;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit tgt, input int per, input bit s, input int tn,
                                input bit gp, input bit err, input int pc, input int pp);
        vec_t v;
        v.tgt = tgt; v.per = per; v.sync = s; v.tn = tn;
        v.gp = gp; v.err = err; v.pc = pc; v.pp = pp;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        vec_t        v;
        logic [31:0] a_fl, a_pc, a_pp, e_fl;
        bit          pend;
        pend = 1'b0;
        for (int i = lo; i < hi; i++) begin
            v = vq[i];
            for (int k = 0; k < v.per - 1; k++) begin
                @(negedge clk);
                if (k == 0 && pend) begin
                    if (v.tgt) check($sformatf("pulse_clear%0d", i), {30'd0, s_gp, s_err}, 32'd0);
                    else       check($sformatf("pulse_clear%0d", i), {30'd0, m_gp, m_err}, 32'd0);
                end
            end
            if (v.tgt) edge_s = 1'b1;
            else       edge_m = 1'b1;
            @(negedge clk);
            edge_s = 1'b0;
            edge_m = 1'b0;
            if (v.tgt) begin
                a_fl = {22'd0, s_stall, s_sync, s_gp, s_err, s_tn};
                a_pc = {24'd0, s_pc};
                a_pp = {24'd0, s_pp};
            end else begin
                a_fl = {22'd0, m_stall, m_sync, m_gp, m_err, m_tn};
                a_pc = {8'd0, m_pc};
                a_pp = {8'd0, m_pp};
            end
            e_fl = {22'd0, 1'b0, v.sync, v.gp, v.err, 6'(v.tn)};
            check($sformatf("vec%0d_flags", i), a_fl, e_fl);
            if (v.pc >= 0) check($sformatf("vec%0d_period_cur", i), a_pc, v.pc);
            if (v.pp >= 0) check($sformatf("vec%0d_period_prev", i), a_pp, v.pp);
            pend = v.gp | v.err;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int end_a, end_r, e0, e1, s0, s1, k_seen;

        // Acquisition: start edge, three teeth, gap, a verified revolution, second gap.
        add(1'b0, 10, 1'b0, 0, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 3; i++) add(1'b0, 100, 1'b0, 0, 1'b0, 1'b0, 100, -1);
        add(1'b0, 300, 1'b0, 0, 1'b0, 1'b0, 300, 100);
        for (int i = 0; i < 57; i++) add(1'b0, 100, 1'b0, 0, 1'b0, 1'b0, 100, -1);
        add(1'b0, 300, 1'b1, 0, 1'b1, 1'b0, 300, 100);
        end_a = vq.size();
        // One revolution in sync; gap of 201 vs prev 100 just qualifies.
        for (int i = 1; i <= 57; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        add(1'b0, 201, 1'b1, 0, 1'b1, 1'b0, 201, 100);
        // Lost tooth 20: merged 200 is not a gap, real gap then arrives early.
        for (int i = 1; i <= 19; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        add(1'b0, 200, 1'b1, 20, 1'b0, 1'b0, 200, 100);
        for (int i = 21; i <= 56; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        add(1'b0, 300, 1'b0, 0, 1'b0, 1'b1, 300, 100);
        // Resync on the next clean revolution.
        for (int i = 0; i < 57; i++) add(1'b0, 100, 1'b0, 0, 1'b0, 1'b0, 100, -1);
        add(1'b0, 300, 1'b1, 0, 1'b1, 1'b0, 300, 100);
        // Run up to tooth 40 before the mid-revolution reset.
        for (int i = 1; i <= 40; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        end_r = vq.size();
        // Extra noise edge splitting tooth 30 into 40 + 60.
        e0 = vq.size();
        for (int i = 1; i <= 29; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        add(1'b0, 40, 1'b1, 30, 1'b0, 1'b0, 40, 100);
        add(1'b0, 60, 1'b1, 31, 1'b0, 1'b0, 60, 40);
        for (int i = 32; i <= 57; i++) add(1'b0, 100, 1'b1, i, 1'b0, 1'b0, 100, -1);
        add(1'b0, 100, 1'b0, 0, 1'b0, 1'b1, 100, 100);
        add(1'b0, 300, 1'b0, 0, 1'b0, 1'b0, 300, 100);
        e1 = vq.size();
        // 8-bit instance: 50-tick teeth, 150-tick gap, then a few teeth in sync.
        s0 = vq.size();
        add(1'b1, 10, 1'b0, 0, 1'b0, 1'b0, 255, -1);
        for (int i = 0; i < 3; i++) add(1'b1, 50, 1'b0, 0, 1'b0, 1'b0, 50, -1);
        add(1'b1, 150, 1'b0, 0, 1'b0, 1'b0, 150, 50);
        for (int i = 0; i < 57; i++) add(1'b1, 50, 1'b0, 0, 1'b0, 1'b0, 50, -1);
        add(1'b1, 150, 1'b1, 0, 1'b1, 1'b0, 150, 50);
        for (int i = 1; i <= 5; i++) add(1'b1, 50, 1'b1, i, 1'b0, 1'b0, 50, -1);
        s1 = vq.size();

        rst    = 1'b1;
        ena    = 1'b1;
        edge_m = 1'b0;
        edge_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", {22'd0, m_stall, m_sync, m_gp, m_err, m_tn}, 32'd0);
        check("reset_periods", {m_pc, m_pp[7:0]}, 32'd0);
        check("reset_flags_s", {22'd0, s_stall, s_sync, s_gp, s_err, s_tn}, 32'd0);
        rst = 1'b0;

        apply(0, end_r);

        // Reset mid-tooth after tooth 40; outputs must clear without a clock edge.
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrev_reset_flags", {22'd0, m_stall, m_sync, m_gp, m_err, m_tn}, 32'd0);
        check("midrev_reset_pc", {8'd0, m_pc}, 32'd0);
        check("midrev_reset_pp", {8'd0, m_pp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply(0, end_a);
        apply(e0, e1);
        apply(s0, s1);

        // Stop the wheel: counter saturates 254 clocks after the last edge.
        k_seen = 0;
        for (int k = 1; k <= 400 && k_seen == 0; k++) begin
            @(negedge clk);
            if (s_stall) k_seen = k;
        end
        check("stall_delay", k_seen, 32'd254);
        check("stall_flags", {23'd0, s_sync, s_gp, s_err, 1'b0, s_tn}, {23'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
        @(negedge clk);
        check("stall_hold", {29'd0, s_stall, s_sync, s_err}, {29'd0, 1'b1, 1'b0, 1'b0});
        repeat (20) @(negedge clk);
        edge_s = 1'b1;
        @(negedge clk);
        edge_s = 1'b0;
        check("stall_clear", {28'd0, s_stall, s_sync, s_err, s_gp}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
